// File: rtl/daq_pkg.sv
// Shared types and constants for the AD7606 readout path and the FIFO reader side.
package daq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CS_SETUP = 3'd1,
        RD_LOW   = 3'd2,
        WR_MSB   = 3'd3,
        WR_LSB   = 3'd4,
        RD_HIGH  = 3'd5,
        DONE     = 3'd6
    } state_e;

    localparam int AD7606_MAX_CH = 8;

    // Byte order of each 16-bit sample on the 8-bit FIFO stream; the reader relies on it.
    localparam bit MSB_FIRST = 1'b1;

    // Selects the first (second_i=0) or second (second_i=1) byte of a word in stream order.
    function automatic logic [7:0] word_byte(input logic [15:0] word_i, input logic second_i);
        logic lsb_sel;
        lsb_sel = (second_i == MSB_FIRST);
        return lsb_sel ? word_i[7:0] : word_i[15:8];
    endfunction

endpackage

// File: rtl/ad7606_readout_ctrl_if.sv
// ADC parallel bus and FIFO write port of the AD7606 readout sequencer.
interface ad7606_readout_ctrl_if;
    logic        cs_o;
    logic        rd_o;
    logic        busy_i;
    logic        frstdata_i;
    logic [15:0] db_i;
    logic        fifo_wrfull_i;
    logic        fifo_wrreq_o;
    logic [7:0]  fifo_data_o;

    modport master (
        output cs_o, rd_o, fifo_wrreq_o, fifo_data_o,
        input  busy_i, frstdata_i, db_i, fifo_wrfull_i
    );

    modport slave (
        input  cs_o, rd_o, fifo_wrreq_o, fifo_data_o,
        output busy_i, frstdata_i, db_i, fifo_wrfull_i
    );
endinterface

// File: rtl/ad7606_readout_ctrl_sync2.sv
// Two-flop synchronizer for the asynchronous AD7606 BUSY line; idles high.
module sync2 (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    // Synchronizer chain, resets to the BUSY idle level.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/ad7606_readout_ctrl.sv
// AD7606 readout sequencer: reads NUM_CH words per conversion into an 8-bit FIFO.
// Optional FRSTDATA alignment check enabled by defining DAQ_FRSTDATA_CHECK_EN.
module ad7606_readout_ctrl
    import daq_pkg::*;
#(
    parameter int NUM_CH      = 8,
    parameter int RD_LOW_CYC  = 2,
    parameter int RD_HIGH_CYC = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  en_i,
    input  logic                  clr_i,
    ad7606_readout_ctrl_if.master bus,
    output logic                  frame_done_o,
    output logic                  overrun_o,
    output logic                  frst_err_o
);

    localparam int CH_W  = $clog2(AD7606_MAX_CH);
    localparam int CNT_W = 8;
    localparam logic [CH_W-1:0]  LAST_CH      = CH_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0] RD_LOW_LAST  = CNT_W'(RD_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] RD_HIGH_LAST = CNT_W'(RD_HIGH_CYC - 1);

    state_e           state_q, state_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [15:0]      db_q, db_d;
    logic [7:0]       data_q, data_d;
    logic             cs_q, cs_d;
    logic             rd_q, rd_d;
    logic             done_q, done_d;
    logic             ovr_q, ovr_d;
    logic             frst_q, frst_d;
    logic             busy_prev_q, busy_prev_d;

    logic busy_sync_s;
    logic fall_s;
    logic capture_s;
    logic wr_go_s;
    logic frst_set_s;

    sync2 u_busy_sync (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .d_i      (bus.busy_i),
        .q_o      (busy_sync_s)
    );

    assign fall_s    = busy_prev_q & ~busy_sync_s;
    assign capture_s = (state_q == RD_LOW) && (cyc_q == RD_LOW_LAST);
    // Full gates the strobe in the same cycle so a byte is never pushed into a full FIFO.
    assign wr_go_s   = ((state_q == WR_MSB) || (state_q == WR_LSB)) && !bus.fifo_wrfull_i;

`ifdef DAQ_FRSTDATA_CHECK_EN
    assign frst_set_s = capture_s &&
                        ((ch_q == '0) ? !bus.frstdata_i : bus.frstdata_i);
`else
    logic frst_unused_s;
    assign frst_unused_s = bus.frstdata_i;
    assign frst_set_s    = 1'b0;
`endif

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        cyc_d       = cyc_q;
        db_d        = db_q;
        data_d      = data_q;
        busy_prev_d = busy_sync_s;

        case (state_q)
            IDLE: begin
                if (fall_s && en_i) begin
                    state_d = CS_SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            CS_SETUP: begin
                state_d = RD_LOW;
                cyc_d   = '0;
            end
            RD_LOW: begin
                if (capture_s) begin
                    state_d = WR_MSB;
                    db_d    = bus.db_i;
                    data_d  = word_byte(bus.db_i, 1'b0);
                end else begin
                    cyc_d = cyc_q + CNT_W'(1);
                end
            end
            WR_MSB: begin
                if (wr_go_s) begin
                    state_d = WR_LSB;
                    data_d  = word_byte(db_q, 1'b1);
                end else begin
                    state_d = WR_MSB;
                end
            end
            WR_LSB: begin
                if (!wr_go_s) begin
                    state_d = WR_LSB;
                end else if (ch_q == LAST_CH) begin
                    state_d = DONE;
                end else begin
                    ch_d    = ch_q + CH_W'(1);
                    cyc_d   = '0;
                    state_d = (RD_HIGH_CYC == 0) ? RD_LOW : RD_HIGH;
                end
            end
            RD_HIGH: begin
                if (cyc_q == RD_HIGH_LAST) begin
                    state_d = RD_LOW;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                ch_d    = '0;
            end
            default: begin
                state_d = IDLE;
                ch_d    = '0;
                cyc_d   = '0;
            end
        endcase

        cs_d   = (state_d == IDLE) || (state_d == DONE);
        rd_d   = (state_d != RD_LOW);
        done_d = (state_d == DONE);

        // Set wins over clear on both sticky flags.
        if (fall_s && (state_q != IDLE)) begin
            ovr_d = 1'b1;
        end else if (clr_i) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end

        if (frst_set_s) begin
            frst_d = 1'b1;
        end else if (clr_i) begin
            frst_d = 1'b0;
        end else begin
            frst_d = frst_q;
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            cyc_q       <= '0;
            db_q        <= 16'h0000;
            data_q      <= 8'h00;
            cs_q        <= 1'b1;
            rd_q        <= 1'b1;
            done_q      <= 1'b0;
            ovr_q       <= 1'b0;
            frst_q      <= 1'b0;
            busy_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            cyc_q       <= cyc_d;
            db_q        <= db_d;
            data_q      <= data_d;
            cs_q        <= cs_d;
            rd_q        <= rd_d;
            done_q      <= done_d;
            ovr_q       <= ovr_d;
            frst_q      <= frst_d;
            busy_prev_q <= busy_prev_d;
        end
    end

    assign bus.cs_o         = cs_q;
    assign bus.rd_o         = rd_q;
    assign bus.fifo_wrreq_o = wr_go_s;
    assign bus.fifo_data_o  = data_q;
    assign frame_done_o     = done_q;
    assign overrun_o        = ovr_q;
    assign frst_err_o       = frst_q;

endmodule

// File: tb/tb_ad7606_readout_ctrl.sv
// Directed scoreboard bench for ad7606_readout_ctrl with a behavioural AD7606 bus model.
module tb_ad7606_readout_ctrl;

    logic clk = 1'b0;
    logic reset_ni;
    logic en_i;
    logic clr_i;
    logic frame_done_o;
    logic overrun_o;
    logic frst_err_o;
    logic frst_good;

    ad7606_readout_ctrl_if bus ();

    ad7606_readout_ctrl dut (
        .clk_i        (clk),
        .reset_ni     (reset_ni),
        .en_i         (en_i),
        .clr_i        (clr_i),
        .bus          (bus),
        .frame_done_o (frame_done_o),
        .overrun_o    (overrun_o),
        .frst_err_o   (frst_err_o)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] sb[$];
    int wr_cnt      = 0;
    int done_cnt    = 0;
    int run_len     = 0;
    int last_len    = 0;
    int cs_fall_cnt = 0;
    logic cs_prev   = 1'b1;
    int rd_rise_cnt = 0;
    int frame_base  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ADC model: word index = rd_o rising edges since cs_o fell.
    always @(posedge bus.rd_o) rd_rise_cnt++;
    always @(negedge bus.cs_o) frame_base = rd_rise_cnt;
    assign bus.db_i       = 16'hA5C3 + 16'(rd_rise_cnt - frame_base);
    assign bus.frstdata_i = (rd_rise_cnt == frame_base) ? frst_good : 1'b0;

    // Output monitor: scoreboard pops, frame_done/cs alignment, cs-low run length.
    always @(negedge clk) begin
        if (bus.fifo_wrreq_o === 1'b1) begin
            wr_cnt++;
            check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                check("fifo_byte", 32'(bus.fifo_data_o), 32'(sb.pop_front()));
            end
        end
        if (frame_done_o === 1'b1) begin
            done_cnt++;
            check("done_cs_high", 32'(bus.cs_o), 32'd1);
        end
        if (bus.cs_o === 1'b0) begin
            run_len++;
            if (cs_prev) cs_fall_cnt++;
        end else if (run_len != 0) begin
            last_len = run_len;
            run_len  = 0;
        end
        cs_prev = bus.cs_o;
    end

    task automatic push_frame();
        logic [15:0] w;
        for (int ch = 0; ch < 8; ch++) begin
            w = 16'hA5C3 + 16'(ch);
            sb.push_back(w[15:8]);
            sb.push_back(w[7:0]);
        end
    endtask

    task automatic pulse_busy();
        @(posedge clk);
        #2 bus.busy_i = 1'b0;
        repeat (4) @(posedge clk);
        #2 bus.busy_i = 1'b1;
    endtask

    task automatic wait_done(input int start_cnt, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_cnt != start_cnt) break;
        end
        repeat (2) @(posedge clk);
        check("frame_done_count", 32'(done_cnt - start_cnt), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cs"},    32'(bus.cs_o),         32'd1);
        check({tag, "_rd"},    32'(bus.rd_o),         32'd1);
        check({tag, "_wrreq"}, 32'(bus.fifo_wrreq_o), 32'd0);
        check({tag, "_data"},  32'(bus.fifo_data_o),  32'd0);
        check({tag, "_done"},  32'(frame_done_o),     32'd0);
        check({tag, "_ovr"},   32'(overrun_o),        32'd0);
        check({tag, "_frst"},  32'(frst_err_o),       32'd0);
    endtask

    initial begin
        int d0;
        int w0;
        int f0;
        logic exp_frst;
        reset_ni          = 1'b0;
        en_i              = 1'b1;
        clr_i             = 1'b0;
        frst_good         = 1'b1;
        bus.busy_i        = 1'b1;
        bus.fifo_wrfull_i = 1'b0;
        #23;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_ni = 1'b1;
        repeat (3) @(posedge clk);

        // Single frame, no back-pressure
        d0 = done_cnt;
        push_frame();
        pulse_busy();
        wait_done(d0, 200);
        check("t1_len", 32'(last_len), 32'd47);
        check("t1_sb_empty", 32'(sb.size()), 32'd0);
        check("t1_ovr", 32'(overrun_o), 32'd0);

        // Back-pressure during ch3 LSB
        d0 = done_cnt;
        w0 = wr_cnt;
        push_frame();
        pulse_busy();
        for (int i = 0; i < 200 && wr_cnt < w0 + 7; i++) @(posedge clk);
        check("t2_reached_ch3", 32'(wr_cnt - w0), 32'd7);
        #1 bus.fifo_wrfull_i = 1'b1;
        repeat (5) @(posedge clk);
        #1 bus.fifo_wrfull_i = 1'b0;
        wait_done(d0, 200);
        check("t2_len", 32'(last_len), 32'd52);
        check("t2_bytes", 32'(wr_cnt - w0), 32'd16);
        check("t2_sb_empty", 32'(sb.size()), 32'd0);

        // Overrun mid-frame
        d0 = done_cnt;
        w0 = wr_cnt;
        push_frame();
        pulse_busy();
        repeat (20) @(posedge clk);
        pulse_busy();
        wait_done(d0, 200);
        repeat (10) @(posedge clk);
        check("t3_single_done", 32'(done_cnt - d0), 32'd1);
        check("t3_bytes", 32'(wr_cnt - w0), 32'd16);
        check("t3_len", 32'(last_len), 32'd47);
        check("t3_ovr_set", 32'(overrun_o), 32'd1);
        @(posedge clk); #1 clr_i = 1'b1;
        @(posedge clk); #1 clr_i = 1'b0;
        check("t3_ovr_clr", 32'(overrun_o), 32'd0);

        // FRSTDATA low at ch0
`ifdef DAQ_FRSTDATA_CHECK_EN
        exp_frst = 1'b1;
`else
        exp_frst = 1'b0;
`endif
        d0 = done_cnt;
        w0 = wr_cnt;
        frst_good = 1'b0;
        push_frame();
        pulse_busy();
        wait_done(d0, 200);
        frst_good = 1'b1;
        check("t4_frst_err", 32'(frst_err_o), 32'(exp_frst));
        check("t4_bytes", 32'(wr_cnt - w0), 32'd16);
        check("t4_sb_empty", 32'(sb.size()), 32'd0);
        @(posedge clk); #1 clr_i = 1'b1;
        @(posedge clk); #1 clr_i = 1'b0;
        check("t4_frst_clr", 32'(frst_err_o), 32'd0);

        // Enable gating
        en_i = 1'b0;
        f0 = cs_fall_cnt;
        d0 = done_cnt;
        pulse_busy();
        repeat (30) @(posedge clk);
        check("t5_no_cs", 32'(cs_fall_cnt - f0), 32'd0);
        check("t5_no_done", 32'(done_cnt - d0), 32'd0);
        check("t5_ovr", 32'(overrun_o), 32'd0);
        en_i = 1'b1;

        // Reset in the middle of ch4
        w0 = wr_cnt;
        push_frame();
        pulse_busy();
        for (int i = 0; i < 200 && wr_cnt < w0 + 8; i++) @(posedge clk);
        check("t6_reached_ch4", 32'(wr_cnt - w0), 32'd8);
        repeat (3) @(negedge clk);
        check("t6_rd_low_before", 32'(bus.rd_o), 32'd0);
        #1 reset_ni = 1'b0;
        #1 check_reset_outputs("t6_async");
        sb.delete();
        repeat (2) @(negedge clk);
        reset_ni = 1'b1;
        repeat (3) @(posedge clk);
        d0 = done_cnt;
        w0 = wr_cnt;
        push_frame();
        pulse_busy();
        wait_done(d0, 200);
        check("t6_bytes", 32'(wr_cnt - w0), 32'd16);
        check("t6_len", 32'(last_len), 32'd47);
        check("t6_sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ad7606_readout_ctrl.md
# ad7606_readout_ctrl

Readout sequencer for one AD7606 ADC channel group in the DAQ packetizer path. After each conversion, signalled by a falling `busy`, it drives `cs`/`rd` to read all channel words from the parallel bus. It splits each 16-bit word into two bytes and pushes them into the 8-bit write port of the async FIFO. It also flags frames lost to FIFO back-pressure and frame misalignment.

## Interface
- `NUM_CH`, 8: channel words read per conversion (1..8).
- `RD_LOW_CYC`, 2: `clk_i` cycles `rd_o` is held low per word (≥1).
- `RD_HIGH_CYC`, 2: extra `rd_o`-high cycles between words, after the byte writes (≥0).
- `clk_i`  in  1  system clock; all logic on rising edge.
- `reset_ni`  in  1  asynchronous, active-low reset.
- `en_i`  in  1  accept new conversions; sampled only in IDLE.
- `clr_i`  in  1  synchronous clear of the sticky flags.
- `busy_i`  in  1  AD7606 BUSY; asynchronous, synchronized internally.
- `frstdata_i`  in  1  AD7606 FRSTDATA.
- `db_i`  in  16  AD7606 parallel data.
- `cs_o`  out  1  chip select, active-low.
- `rd_o`  out  1  read strobe, active-low.
- `fifo_wrfull_i`  in  1  FIFO write-side full.
- `fifo_wrreq_o`  out  1  FIFO write request, one byte per cycle.
- `fifo_data_o`  out  8  FIFO write data.
- `frame_done_o`  out  1  one-cycle pulse when a frame completes.
- `overrun_o`  out  1  sticky: a busy falling edge arrived while not IDLE.
- `frst_err_o`  out  1  sticky: FRSTDATA misaligned.

## Operation
- **Reset values:** `cs_o`=1, `rd_o`=1, `fifo_wrreq_o`=0, `fifo_data_o`=0, `frame_done_o`=0, `overrun_o`=0, `frst_err_o`=0. State is IDLE, channel counter 0, sync flops 1.
- **Edge detection:** `busy_i` passes through a 2-flop synchronizer. A falling edge is sync output 0 with its registered previous value at 1.
- **IDLE:** on a falling edge with `en_i`=1, go to CS_SETUP. If `en_i`=0, the edge is ignored silently.
- **CS_SETUP:** one cycle, `cs_o`=0, then RD_LOW.
- **RD_LOW:** `rd_o`=0 for `RD_LOW_CYC` cycles.
  - `db_i` is captured on the last low cycle.
  - On channel 0, `frstdata_i` is checked at the same point; on channels >0 it must be 0.
  - Then go to WR_MSB with `rd_o`=1.
- **WR_MSB, then WR_LSB:** `fifo_wrreq_o`=1, `fifo_data_o`=`db[15:8]`, then `db[7:0]`. A write is issued only when `fifo_wrfull_i`=0; otherwise the FSM stalls in that state with `fifo_wrreq_o`=0. Bytes are never dropped.
- **After WR_LSB:**
  - If the counter equals `NUM_CH-1`, go to DONE.
  - Otherwise increment the counter and go to RD_HIGH, which holds for `RD_HIGH_CYC` cycles (skipped if 0), then RD_LOW.
- **DONE:** `cs_o`=1, `frame_done_o`=1 for one cycle, counter cleared, then IDLE.
- **Overrun:** a falling edge detected in any state other than IDLE sets `overrun_o` and is discarded. The current frame completes normally.
- **Sticky flags:** `clr_i` clears both flags. If `clr_i` and a set event coincide, set wins.
- **Mid-frame reset:** `reset_ni` low returns all outputs to reset values immediately. No partial frame is resumed.

## Timing
- `busy_i` falls between edges E(−1) and E0. The sync output falls after E1. The FSM leaves IDLE at E2, so `cs_o`=0 is visible after E2.
- `rd_o` first falls one cycle after `cs_o`.
- Stall-free frame length, from `cs_o` low to `cs_o` high: 1 + NUM_CH·(RD_LOW_CYC+2+RD_HIGH_CYC) − RD_HIGH_CYC cycles. With defaults this is 47 cycles.
- `frame_done_o` coincides with the first cycle `cs_o` is high again.
- Bytes enter the FIFO in order ch0 MSB, ch0 LSB, ch1 MSB, …; 2·NUM_CH bytes per frame.
- `en_i` deasserted mid-frame has no effect until IDLE.

## Configuration
- **`DAQ_FRSTDATA_CHECK_EN` defined:**
  - `frst_err_o` sets if `frstdata_i`=0 at the channel-0 capture, or 1 at any other capture.
  - The frame is still written in full.
- **Undefined:** `frstdata_i` is unused and `frst_err_o` is tied 0.

## Structure
- **Package `daq_pkg`:** state enum (IDLE, CS_SETUP, RD_LOW, WR_MSB, WR_LSB, RD_HIGH, DONE) and `AD7606_MAX_CH`=8. It also holds byte-order constant MSB_FIRST, shared with the FIFO reader side.
- **Sub-module `sync2`:** two-flop synchronizer for `busy_i`, reset to 1.

## Test plan
- **Single frame, defaults, FIFO never full:**
  - Drive `db_i`=16'hA5C3+ch and pulse `busy_i`.
  - Expected: 16 bytes A5,C3,A5,C4,…,A5,CA.
  - Expected: `cs_o` low for 47 cycles and one `frame_done_o`.
- **Back-pressure:** hold `fifo_wrfull_i`=1 for 5 cycles during ch3 WR_LSB.
  - Expected: FSM stalls exactly 5 cycles and no byte is lost or duplicated.
  - Expected: frame is 52 cycles.
- **Overrun:** pulse `busy_i` again 20 cycles into a frame.
  - Expected: `overrun_o`=1, still exactly 16 bytes and one `frame_done_o`.
  - Then `clr_i` → `overrun_o`=0.
- **FRSTDATA error (macro defined):** hold `frstdata_i`=0 at ch0.
  - Expected: `frst_err_o`=1 and the full 16 bytes are still written.
  - With the macro undefined, `frst_err_o` stays 0.
- **Enable gating:** `en_i`=0 with a busy edge.
  - Expected: no `cs_o` activity and `overrun_o` stays 0.
- **Reset mid-frame:** assert `reset_ni` at ch4.
  - Expected: outputs return to reset values asynchronously.
  - Expected: the next busy edge produces a clean 16-byte frame starting at ch0.
